seq_shifter: RTL and testbench
==============================

Name: seq_shifter

Overview:
- Multi-cycle shift engine for the datapath. Applies the standard 2-bit shift operation `amount` times, one bit position per clock.
- Shift encoding: 00 pass, 01 left-logical, 10 right-logical, 11 right-arithmetic.
- Sits beside the combinational single-bit shifter. Used when the controller needs shift distances 0-15.
- Uses a start/busy/done handshake, so the controller FSM can stall until the result is valid.

Parameters:
- WIDTH, 16, data width in bits.
- AMT_W, 4, width of the shift-amount field (max distance 2^AMT_W-1).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled on rising clk edge
- in  in  WIDTH  operand, latched on accepted start
- shift  in  2  operation code, latched on accepted start
- amount  in  AMT_W  number of one-bit steps, latched on accepted start
- sout  out  WIDTH  working/result register; valid while done=1 and held until next accepted start
- busy  out  1  high while shifting; start ignored
- done  out  1  one-cycle pulse: result valid

Behaviour:
- One clock (clk); reset is synchronous and active-high. Reset sampled at a clk edge overrides all other inputs.
- Reset values: state=IDLE, sout=0, cnt=0, busy=0, done=0.
- States:
  - IDLE: busy=0, done=0.
  - SHIFT: busy=1, done=0.
  - DONE: busy=0, done=1.
- Start acceptance: start=1 at an edge while state is IDLE or DONE.
  - Latches sout<=in, op<=shift, cnt<=amount.
  - Next state is SHIFT if amount!=0, else DONE.
- SHIFT: each edge applies exactly one step to sout and decrements cnt. When cnt==1 at that edge, next state is DONE.
- Per-step ops (W=WIDTH):
  - 00: sout unchanged.
  - 01: {sout[W-2:0],1'b0}.
  - 10: {1'b0,sout[W-1:1]}.
  - 11: {sout[W-1],sout[W-1:1]}.
- Op 00 with amount>0 still iterates, so latency is uniform.
- DONE: lasts one cycle, then IDLE unless a new start is accepted in that cycle.
- Latency: if start is accepted at edge k, done is high in the cycle after edge k+amount. Total latency is amount+1 cycles for all amount values, including 0.
- start while busy=1 is ignored. Latched operands are unaffected; no queueing.
- in/shift/amount may change freely after acceptance; only the latched copies are used.
- Reset mid-SHIFT: next cycle is IDLE with sout=0. No done pulse; the partial result is discarded.
- Shifting past the width:
  - Logical ops saturate to 0.
  - Arithmetic right saturates to all-copies of the original bit W-1.
  - No wrap-around.
- sout during SHIFT shows intermediate values; consumers must qualify it with done.

Test Plan:
- Reset, then in=16'hF0CF, shift=01, amount=1, start pulse. Required: busy=1 for 1 cycle, then done=1 with sout=16'hE19E, then IDLE with sout held.
- in=16'd41, shift=01, amount=3. Required: done after 4 cycles with sout=16'd328; amount=0 with the same in gives done after 1 cycle with sout=16'd41.
- in=16'h800D, shift=11, amount=4. Required: sout=16'hF800. Same with shift=10: sout=16'h0800. Same with amount=15, shift=11: sout=16'hFFFF.
- in=16'hFFFF, shift=10, amount=15. Required: sout=16'h0001 after 16 cycles. Pulsing start with different operands during busy leaves the result unchanged.
- Assert start in the DONE cycle with new operands (in=16'h0003, shift=01, amount=2). Required: accepted back-to-back, the next done gives sout=16'h000C, and each done lasts exactly 1 cycle.
- Assert reset 3 cycles into amount=8. Required: next cycle sout=0, busy=0, done=0, and no done pulse afterwards.

Source files
------------

// File: rtl/seq_shifter.sv
// Multi-cycle shift engine: applies a 2-bit shift op `amount` times, one bit per clock,
// behind a start/busy/done handshake.
module seq_shifter #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       shift,
  input  logic [AMT_W-1:0] amount,
  output logic [WIDTH-1:0] sout,
  output logic             busy,
  output logic             done
);

  // Handshake: start is accepted on a rising edge whenever busy=0 (IDLE or DONE);
  // the operands are latched at that edge. busy stays high while stepping and
  // start is ignored. done is a one-cycle pulse that qualifies sout, which then
  // holds until the next accepted start.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [1:0]       op;
  logic [AMT_W-1:0] cnt;

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] v, input logic [1:0] code);
    logic [WIDTH-1:0] r;
    case (code)
      2'b01:   r = {v[WIDTH-2:0], 1'b0};
      2'b10:   r = {1'b0, v[WIDTH-1:1]};
      2'b11:   r = {v[WIDTH-1], v[WIDTH-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      sout  <= '0;
      op    <= 2'b00;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            sout <= in;
            op   <= shift;
            cnt  <= amount;
            if (amount != '0) begin
              state <= S_SHIFT;
              busy  <= 1'b1;
              done  <= 1'b0;
            end else begin
              // Zero distance still costs one cycle so latency is amount+1 everywhere.
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        S_SHIFT: begin
          sout <= step(sout, op);
          cnt  <= cnt - 1'b1;
          if (cnt == AMT_W'(1)) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: driver tasks issue operations, a monitor pops expected
// results (value and completion cycle) whenever done is seen.
module tb_seq_shifter;
  localparam int W = 16;
  localparam int A = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] in;
  logic [1:0]   shift;
  logic [A-1:0] amount;
  logic [W-1:0] sout;
  logic         busy;
  logic         done;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_seen = 0;
  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];

  seq_shifter #(.WIDTH(W), .AMT_W(A)) dut (
    .clk(clk), .reset(reset), .start(start), .in(in), .shift(shift),
    .amount(amount), .sout(sout), .busy(busy), .done(done)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: whole-distance shift with plain operators
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] x, input logic [1:0] op, input int a);
    logic signed [W-1:0] s;
    s = x;
    case (op)
      2'b01:   return x << a;
      2'b10:   return x >> a;
      2'b11:   return W'(s >>> a);
      default: return x;
    endcase
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (!reset && done) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: done=1 with nothing outstanding, sout=%h (cycle %0d)", sout, cyc);
      end else begin
        check("result", sout, exp_q.pop_front());
        check("latency", W'(cyc), W'(exp_cyc_q.pop_front()));
      end
    end
  end

  task automatic issue(input logic [W-1:0] d, input logic [1:0] op, input logic [A-1:0] amt);
    int budget = 0;
    @(negedge clk);
    while (busy && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL busy_timeout: busy=%b expected 0 within 40 cycles", busy);
      return;
    end
    start = 1'b1; in = d; shift = op; amount = amt;
    exp_q.push_back(ref_shift(d, op, int'(amt)));
    exp_cyc_q.push_back(cyc + 1 + int'(amt));
    @(negedge clk);
    start = 1'b0;
    in = W'($urandom); shift = 2'($urandom); amount = A'($urandom);
  endtask

  task automatic poke_while_busy(input int n);
    repeat (n) begin
      @(negedge clk);
      start = busy;
      in = W'($urandom); shift = 2'($urandom); amount = A'($urandom_range(1, 15));
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int budget = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  task automatic check_idle_held(input string name, input logic [W-1:0] val);
    @(negedge clk);
    check({name, "_sout"}, sout, val);
    check({name, "_busy"}, W'(busy), W'(0));
    check({name, "_done"}, W'(done), W'(0));
  endtask

  initial begin
    int seen;
    reset = 1'b1; start = 1'b0; in = '0; shift = 2'b00; amount = '0;
    repeat (3) @(negedge clk);
    check("reset_sout", sout, '0);
    check("reset_busy", W'(busy), W'(0));
    check("reset_done", W'(done), W'(0));
    reset = 1'b0;

    issue(16'hF0CF, 2'b01, 4'd1);
    drain();
    check_idle_held("after_f0cf", 16'hE19E);

    issue(16'd41, 2'b01, 4'd3);
    issue(16'd41, 2'b01, 4'd0);
    issue(16'h800D, 2'b11, 4'd4);
    issue(16'h800D, 2'b10, 4'd4);
    issue(16'h800D, 2'b11, 4'd15);
    drain();

    issue(16'hFFFF, 2'b10, 4'd15);
    poke_while_busy(6);
    drain();
    check_idle_held("after_ffff", 16'h0001);

    // Back-to-back: second start lands in the DONE cycle of the first.
    issue(16'h1234, 2'b10, 4'd2);
    issue(16'h0003, 2'b01, 4'd2);
    issue(16'h0005, 2'b00, 4'd0);
    issue(16'h0005, 2'b00, 4'd3);
    drain();

    // Reset mid-shift discards the partial result.
    issue(16'hABCD, 2'b11, 4'd8);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    exp_cyc_q.delete();
    @(negedge clk);
    check("midreset_sout", sout, '0);
    check("midreset_busy", W'(busy), W'(0));
    check("midreset_done", W'(done), W'(0));
    reset = 1'b0;
    seen = done_seen;
    repeat (12) @(negedge clk);
    check("no_done_after_reset", W'(done_seen), W'(seen));

    for (int i = 0; i < 60; i++) begin
      issue(W'($urandom), 2'($urandom), A'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) poke_while_busy($urandom_range(1, 4));
      if ($urandom_range(0, 2) == 0) drain();
    end
    drain();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
